// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment scan path.
//   state_t      : scan FSM states
//   SEG_W_DEFAULT: default segment bus width, bit order {g,f,e,d,c,b,a}
//   SEG_OFF      : all segments dark (active-high encoding)
//   SEG_0..SEG_9 : decimal digit codes, also used by the accumulator LUT
//   digit_code   : maps 0-9 to its segment code, anything else to SEG_OFF
package seg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        DRIVE
    } state_t;

    localparam int SEG_W_DEFAULT = 7;

    localparam logic [6:0] SEG_OFF = 7'h00;
    localparam logic [6:0] SEG_0   = 7'h3F;
    localparam logic [6:0] SEG_1   = 7'h06;
    localparam logic [6:0] SEG_2   = 7'h5B;
    localparam logic [6:0] SEG_3   = 7'h4F;
    localparam logic [6:0] SEG_4   = 7'h66;
    localparam logic [6:0] SEG_5   = 7'h6D;
    localparam logic [6:0] SEG_6   = 7'h7D;
    localparam logic [6:0] SEG_7   = 7'h07;
    localparam logic [6:0] SEG_8   = 7'h7F;
    localparam logic [6:0] SEG_9   = 7'h6F;

    function automatic logic [6:0] digit_code(input int unsigned d);
        case (d)
            0:       return SEG_0;
            1:       return SEG_1;
            2:       return SEG_2;
            3:       return SEG_3;
            4:       return SEG_4;
            5:       return SEG_5;
            6:       return SEG_6;
            7:       return SEG_7;
            8:       return SEG_8;
            9:       return SEG_9;
            default: return SEG_OFF;
        endcase
    endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Cycle counter for the digit scanner.
//   clk   : clock
//   rst   : synchronous active-high reset
//   clr   : synchronous clear to zero (has priority over counting)
//   limit : terminal count value
//   tc    : high while the count equals limit
// The owner clears the counter on terminal count, so it never wraps by overflow.
module seg_scan_timer
    import seg_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic [W-1:0] limit,
    output logic         tc
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == limit);

endmodule

// File: rtl/seg_scan_axis.sv
// AXI-Stream sink that time-multiplexes a packed 7-segment frame onto a shared
// segment bus with blanking gaps, swapping frames only at scan boundaries.
//   clk        : clock, all logic on posedge
//   rst        : synchronous active-high reset
//   s_valid    : upstream frame valid
//   s_ready    : pending slot free
//   s_data     : frame, s_data[i] is the code for digit i (digit 0 = ones)
//   seg        : shared segment bus, registered
//   dig_en     : digit enables, one-hot or all-off, registered
//   frame_done : one-cycle pulse after the last digit of each scan
module seg_scan_axis
    import seg_pkg::*;
#(
    parameter int NO_OF_DIGITS   = 2,
    parameter int SEG_W          = SEG_W_DEFAULT,
    parameter int REFRESH_CYCLES = 1000,
    parameter int BLANK_CYCLES   = 2,
    parameter bit ACTIVE_LOW     = 1'b0
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 s_valid,
    output logic                                 s_ready,
    input  logic [NO_OF_DIGITS-1:0][SEG_W-1:0]   s_data,
    output logic [SEG_W-1:0]                     seg,
    output logic [NO_OF_DIGITS-1:0]              dig_en,
    output logic                                 frame_done
);

    localparam int IDX_W   = (NO_OF_DIGITS > 1) ? $clog2(NO_OF_DIGITS) : 1;
    localparam int MAX_CNT = (REFRESH_CYCLES > BLANK_CYCLES) ? REFRESH_CYCLES : BLANK_CYCLES;
    localparam int TMR_W   = $clog2(MAX_CNT + 1);

    localparam logic [TMR_W-1:0] DRIVE_LIM = TMR_W'(REFRESH_CYCLES - 1);
    localparam logic [TMR_W-1:0] BLANK_LIM = TMR_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NO_OF_DIGITS - 1);
    localparam state_t           GAP_NEXT  = (BLANK_CYCLES > 0) ? BLANK : DRIVE;

    localparam logic [SEG_W-1:0]        SEG_POL = ACTIVE_LOW ? '1 : '0;
    localparam logic [NO_OF_DIGITS-1:0] DIG_POL = ACTIVE_LOW ? '1 : '0;

    state_t                              state, state_n;
    logic [IDX_W-1:0]                    idx, idx_n;
    logic [NO_OF_DIGITS-1:0][SEG_W-1:0]  disp, disp_n;
    logic [NO_OF_DIGITS-1:0][SEG_W-1:0]  pend, pend_n;
    logic                                pend_valid, pend_valid_n;
    logic                                fd_n;
    logic [SEG_W-1:0]                    seg_n;
    logic [NO_OF_DIGITS-1:0]             dig_n;
    logic                                tmr_clr;
    logic                                tmr_tc;
    logic [TMR_W-1:0]                    tmr_limit;

    assign s_ready   = ~pend_valid;
    assign tmr_limit = (state == BLANK) ? BLANK_LIM : DRIVE_LIM;

    seg_scan_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clr   (tmr_clr),
        .limit (tmr_limit),
        .tc    (tmr_tc)
    );

    always_comb begin
        state_n      = state;
        idx_n        = idx;
        disp_n       = disp;
        pend_n       = pend;
        pend_valid_n = pend_valid;
        fd_n         = 1'b0;
        tmr_clr      = 1'b0;

        case (state)
            IDLE: begin
                tmr_clr = 1'b1;
                if (pend_valid) begin
                    disp_n       = pend;
                    pend_valid_n = 1'b0;
                    idx_n        = '0;
                    state_n      = GAP_NEXT;
                end
            end
            BLANK: begin
                if (tmr_tc) begin
                    tmr_clr = 1'b1;
                    state_n = DRIVE;
                end
            end
            DRIVE: begin
                if (tmr_tc) begin
                    tmr_clr = 1'b1;
                    state_n = GAP_NEXT;
                    if (idx < LAST_IDX) begin
                        idx_n = idx + 1'b1;
                    end else begin
                        fd_n  = 1'b1;
                        idx_n = '0;
                        if (pend_valid) begin
                            disp_n       = pend;
                            pend_valid_n = 1'b0;
                        end
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // A load needs pend_valid=1, which holds s_ready low, so accept and
        // load never collide on the same edge.
        if (s_valid && !pend_valid) begin
            pend_n       = s_data;
            pend_valid_n = 1'b1;
        end

        // Outputs are registered from the next state so they line up with it.
        seg_n = '0;
        dig_n = '0;
        if (state_n == DRIVE) begin
            seg_n        = disp_n[idx_n];
            dig_n[idx_n] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            disp       <= '0;
            pend       <= '0;
            pend_valid <= 1'b0;
            seg        <= SEG_POL;
            dig_en     <= DIG_POL;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            disp       <= disp_n;
            pend       <= pend_n;
            pend_valid <= pend_valid_n;
            seg        <= seg_n ^ SEG_POL;
            dig_en     <= dig_n ^ DIG_POL;
            frame_done <= fd_n;
        end
    end

endmodule
